// File: rtl/offset_arbiter_ctrl.sv
// offset_arbiter_ctrl: round-robin arbiter sharing one offset counter between
// two requesters. Each grant runs a LOAD (wrap value to counter), then len
// increment cycles (RUN), then a one-cycle DONE back to IDLE.
//
// Handshake: reqN is a level held by requester N until ackN. A req is sampled
// only in IDLE; ackN pulses for one cycle in the cycle after that sample and
// means modN/lenN were captured on the sampling edge. doneN pulses for one
// cycle when the burst has finished. Once granted, a burst always completes
// (only reset stops it); req activity outside IDLE is ignored.
module offset_arbiter_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] mod0,
  input  logic [31:0] mod1,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic        busy,
  output logic        owner,
  output logic        load_temp,
  output logic [31:0] temp_reg,
  output logic        plus_1,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_served;
  logic [15:0] remaining;
  logic        grant_valid;
  logic        grant_idx;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = (req0 && req1) ? ~last_served : req1;
  end

  // Next-state logic; remaining holds the latched len while in LOAD.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_valid) state_next = LOAD;
      LOAD: state_next = (remaining != 16'd0) ? RUN : DONE;
      RUN:  if (remaining == 16'd1) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Grant capture, burst length countdown and last-served bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      temp_reg    <= 32'd0;
      remaining   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_idx;
            temp_reg  <= grant_idx ? mod1 : mod0;
            remaining <= grant_idx ? len1 : len0;
          end
        end
        RUN:  remaining   <= remaining - 16'd1;
        DONE: last_served <= owner;
        default: ;
      endcase
    end
  end

  // Strobes decoded purely from registered state and owner.
  always_comb begin
    busy      = (state != IDLE);
    load_temp = (state == LOAD);
    plus_1    = (state == RUN);
    ack0      = (state == LOAD) && !owner;
    ack1      = (state == LOAD) &&  owner;
    done0     = (state == DONE) && !owner;
    done1     = (state == DONE) &&  owner;
    state_dbg = state;
  end

endmodule

// File: tb/tb_offset_arbiter_ctrl.sv
// Bench for offset_arbiter_ctrl: reset checks, table of single bursts,
// hand-written multi-cycle sequences and a randomized soak against a
// cycle-arithmetic reference model.
module tb_offset_arbiter_ctrl;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [31:0] mod0, mod1;
  logic [15:0] len0, len1;
  logic        ack0, ack1, done0, done1, busy, owner, load_temp, plus_1;
  logic [31:0] temp_reg;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  offset_arbiter_ctrl dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .mod0(mod0), .mod1(mod1),
    .len0(len0), .len1(len1),
    .ack0(ack0), .ack1(ack1),
    .done0(done0), .done1(done1),
    .busy(busy), .owner(owner),
    .load_temp(load_temp), .temp_reg(temp_reg),
    .plus_1(plus_1), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [15:0] l0;
    logic [15:0] l1;
    logic        exp_idx;
    logic [31:0] exp_mod;
    int          exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; leaves the DUT freshly reset, again at posedge+1.
  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One burst from IDLE: check ack timing, captured mod, plus_1 run and done.
  task automatic run_burst(input vec_t v, input string tag);
    int  plus_cnt;
    int  done_k;
    bit  got_done;
    req0 = v.r0; req1 = v.r1;
    mod0 = v.m0; mod1 = v.m1;
    len0 = v.l0; len1 = v.l1;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    mod0 = ~v.m0; mod1 = ~v.m1;
    @(negedge clk);
    check({tag, "_ack"}, {62'd0, ack1, ack0}, v.exp_idx ? 64'd2 : 64'd1);
    check({tag, "_load"}, {62'd0, load_temp, plus_1}, 64'd2);
    check({tag, "_temp"}, {32'd0, temp_reg}, {32'd0, v.exp_mod});
    plus_cnt = 0; got_done = 0; done_k = -1;
    for (int k = 0; k <= v.exp_len + 1 && !got_done; k++) begin
      @(negedge clk);
      if (done0 || done1) begin
        got_done = 1;
        done_k = k;
        check({tag, "_done_idx"}, {62'd0, done1, done0}, v.exp_idx ? 64'd2 : 64'd1);
      end else if (plus_1) begin
        plus_cnt++;
      end
    end
    check({tag, "_done_cycle"}, done_k, v.exp_len);
    check({tag, "_plus_cnt"}, plus_cnt, v.exp_len);
    check({tag, "_temp_hold"}, {32'd0, temp_reg}, {32'd0, v.exp_mod});
    @(negedge clk);
    check({tag, "_idle_after"}, {62'd0, busy, plus_1}, 64'd0);
    @(posedge clk); #1;
  endtask

  // Soak reference model: burst timing expressed as arithmetic on grant cycle.
  int          m_g, m_len, m_free;
  logic        m_w, m_last, m_own;
  logic [31:0] m_tmp;

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int pc, dn, done_cyc, ack1_cyc, plus_cnt, temp_bad;
    logic e_ack, e_run, e_done, e_busy;
    logic [39:0] exp_v, act_v;

    reset = 1'b1;
    req0 = 0; req1 = 0; mod0 = 0; mod1 = 0; len0 = 0; len1 = 0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_strobes", {58'd0, ack0, ack1, done0, done1, load_temp, plus_1}, 64'd0);
    check("rst_busy_owner", {62'd0, busy, owner}, 64'd0);
    check("rst_temp", {32'd0, temp_reg}, 64'd0);
    check("rst_state", {62'd0, state_dbg}, 64'd0);
    @(posedge clk); #1;

    // Table of single bursts, each from a fresh reset
    vecs[0] = '{1'b1, 1'b0, 32'd5,          32'd0, 16'd7,      16'd0, 1'b0, 32'd5,          7};
    vecs[1] = '{1'b0, 1'b1, 32'd0,          32'd9, 16'd0,      16'd0, 1'b1, 32'd9,          0};
    vecs[2] = '{1'b1, 1'b1, 32'd21,         32'd22, 16'd3,     16'd4, 1'b0, 32'd21,         3};
    vecs[3] = '{1'b0, 1'b1, 32'd3,          32'd0, 16'd5,      16'd1, 1'b1, 32'd0,          1};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'd1, 16'd2,      16'd9, 1'b0, 32'hFFFF_FFFF,  2};
    vecs[5] = '{1'b1, 1'b0, 32'd3,          32'd4, 16'hFFFF,   16'd1, 1'b0, 32'd3,          65535};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_burst(vecs[i], $sformatf("vec%0d", i));
    end

    // Round robin with both requests held: 0, then 1, then 0
    do_reset();
    exp_q = {64'd0, 64'd1, 64'd0};
    req0 = 1; req1 = 1; mod0 = 32'd1; mod1 = 32'd2; len0 = 16'd2; len1 = 16'd2;
    for (int k = 0; k < 40 && got_q.size() < 3; k++) begin
      @(negedge clk);
      if (ack0) got_q.push_back(64'd0);
      if (ack1) got_q.push_back(64'd1);
    end
    check("rr_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("rr_grant%0d", i), (i < got_q.size()) ? got_q[i] : 64'hDEAD, exp_q[i]);
    @(posedge clk); #1;

    // Reset during the 4th plus_1 cycle: no done afterwards
    do_reset();
    req0 = 1; req1 = 0; mod0 = 32'h1234; len0 = 16'd10;
    @(posedge clk); #1;
    req0 = 0;
    pc = 0;
    for (int k = 0; k < 20 && pc < 4; k++) begin
      @(negedge clk);
      if (plus_1) pc++;
    end
    check("mid_rst_reach4", pc, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_strobes", {58'd0, ack0, ack1, done0, done1, load_temp, plus_1}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_temp", {32'd0, temp_reg}, 64'd0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done0 || done1 || plus_1) dn++;
    end
    check("mid_rst_no_done", dn, 0);
    @(posedge clk); #1;

    // Input churn during a req0 burst must not disturb it; req1 waits
    do_reset();
    req0 = 1; req1 = 0; mod0 = 32'd7; len0 = 16'd6; mod1 = 32'd11; len1 = 16'd1;
    @(posedge clk); #1;
    done_cyc = -1; ack1_cyc = -1; plus_cnt = 0; temp_bad = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (done_cyc < 0) begin
        if (plus_1) plus_cnt++;
        if (temp_reg !== 32'd7) temp_bad++;
      end
      if (done0 && done_cyc < 0) done_cyc = cyc;
      if (ack1 && ack1_cyc < 0) ack1_cyc = cyc;
      @(posedge clk); #1;
      req0 = $urandom_range(0, 1);
      mod0 = $urandom;
      len0 = $urandom_range(0, 20);
      req1 = 1;
    end
    check("churn_plus_cnt", plus_cnt, 6);
    check("churn_temp_hold", temp_bad, 0);
    check("churn_done_cycle", done_cyc, 7);
    check("churn_ack1_cycle", ack1_cyc, 9);

    // Randomized soak against the reference model
    do_reset();
    m_g = -1000; m_len = 0; m_free = 0; m_last = 1; m_own = 0; m_tmp = 0; m_w = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      mod0 = $urandom; mod1 = $urandom;
      len0 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      len1 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      @(negedge clk);
      e_ack  = (c == m_g + 1);
      e_run  = (c >= m_g + 2) && (c <= m_g + 1 + m_len);
      e_done = (c == m_g + 2 + m_len);
      e_busy = (c >= m_g + 1) && (c <= m_g + 2 + m_len);
      exp_v = {e_ack && !m_w, e_ack && m_w, e_done && !m_w, e_done && m_w,
               e_busy, m_own, e_ack, e_run, m_tmp};
      act_v = {ack0, ack1, done0, done1, busy, owner, load_temp, plus_1, temp_reg};
      check($sformatf("soak_c%0d", c), {24'd0, act_v}, {24'd0, exp_v});
      if (c >= m_free && (req0 || req1)) begin
        m_w    = (req0 && req1) ? ~m_last : req1;
        m_g    = c;
        m_len  = m_w ? int'(len1) : int'(len0);
        m_tmp  = m_w ? mod1 : mod0;
        m_own  = m_w;
        m_last = m_w;
        m_free = c + 3 + m_len;
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/offset_arbiter_ctrl.md
OFFSET_ARBITER_CTRL -- requirements
Module: offset_arbiter_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req0 / req1  input  1 each  burst request from requester 0 / 1; level, held until ack.
REQ-005 mod0 / mod1  input  32 each  wrap value for the offset counter; sampled at grant.
REQ-006 len0 / len1  input  16 each  number of increments in the burst; sampled at grant.
REQ-007 ack0 / ack1  output  1 each  one-cycle pulse: request accepted, mod/len captured.
REQ-008 done0 / done1  output  1 each  one-cycle pulse: burst complete.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 owner  output  1  index of the requester currently or last granted.
REQ-011 load_temp  output  1  load strobe to the offset counter.
REQ-012 temp_reg  output  32  wrap value driven to the offset counter.
REQ-013 plus_1  output  1  increment strobe to the offset counter.

Function
REQ-014 The block SHALL arbitrate one shared offset counter between two requesters and sequence a load-then-increment burst per grant.
REQ-015 FSM states SHALL be IDLE, LOAD, RUN and DONE, with transitions evaluated on each rising clk edge.
REQ-016 In IDLE with any req high: grant per REQ-017, latch mod/len of the winner, set owner, go to LOAD.
REQ-016a In IDLE with no req high: stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both req are high, grant the requester not served last; a single req is granted directly.
REQ-017a After reset the "last served" marker SHALL be 1, so req0 wins the first tie.
REQ-018 LOAD lasts one cycle: ack[owner]=1 and load_temp=1.
REQ-018a From LOAD, go to RUN if latched len != 0, else go to DONE.
REQ-019 temp_reg SHALL hold the latched mod value continuously from LOAD until the next grant, not only during load_temp.
REQ-020 RUN: plus_1=1 every cycle; a 16-bit remaining counter initialised to len decrements each cycle.
REQ-020a When remaining==1 in RUN: that is the last plus_1 cycle; go to DONE.
REQ-020b A burst of length len SHALL produce exactly len plus_1 cycles, contiguous.
REQ-021 DONE lasts one cycle: done[owner]=1, update the last-served marker to owner, go to IDLE.
REQ-022 Latency: req sampled in IDLE at cycle t gives ack/load_temp at t+1, plus_1 at t+2..t+1+len, done at t+2+len.
REQ-022a The next grant SHALL be sampled no earlier than t+3+len.
REQ-023 A burst SHALL NOT be aborted: req changes, or the other req, during LOAD/RUN/DONE SHALL have no effect.
REQ-023a A req dropped before being sampled in IDLE SHALL be ignored, with no ack.
REQ-024 mod=0 SHALL pass through unchanged; it is not treated as an error.
REQ-024a len=0xFFFF SHALL produce 65535 plus_1 cycles with no wrap of the remaining counter.
REQ-025 ack0/ack1, done0/done1 and load_temp/plus_1 SHALL each be mutually exclusive; load_temp and plus_1 SHALL never be high together.
REQ-026 All outputs SHALL be registered or decoded solely from registered state; no combinational path from inputs to outputs.

Reset
REQ-027 On reset: state=IDLE, busy=0, owner=0, last-served=1, temp_reg=0, remaining=0.
REQ-027a On reset: all ack/done/load_temp/plus_1 = 0.
REQ-028 Reset mid-burst SHALL take effect on the next edge: plus_1 stops immediately and no done pulse is issued.
REQ-028a The interrupted requester SHALL re-request after reset.
REQ-029 The offset counter shares the same reset; after reset the block makes no assumption about its count beyond count=0.

Verification
REQ-030 req0=1, mod0=5, len0=7 -> ack0 at t+1 with load_temp=1 and temp_reg=5; plus_1 high t+2..t+8; done0 at t+9; counter sequence 1,2,3,4,0,1,2.
REQ-031 req0=req1=1 from reset, len=2 each -> req0 granted first; req1 granted at the first IDLE after done0; then with both still high, req0 granted again.
REQ-032 req1=1, len1=0, mod1=9 -> ack1+load_temp at t+1, no plus_1, done1 at t+2, temp_reg=9.
REQ-033 Burst len0=10; reset asserted during the 4th plus_1 cycle -> next cycle all strobes 0, busy=0, temp_reg=0, no done0.
REQ-034 During req0 burst, toggle req0 and mod0 and raise req1 -> plus_1 count stays len0, temp_reg unchanged, req1 acked only after done0.
REQ-035 Random req/mod/len soak (10k cycles) -> every ack followed by exactly one done of the same index after len+1 cycles; no overlap of load_temp and plus_1.
